// File: rtl/exibe_sequencia_pkg.sv
// exibe_sequencia_pkg: state codes, widths and helpers shared by the
// sequence-presentation unit, its timer and its bus interface.
package exibe_sequencia_pkg;

   localparam int ADDR_W = 4;
   localparam int DATA_W = 4;
   localparam int DBG_W  = 4;

   typedef enum logic [2:0] {
      INICIAL = 3'd0,
      BUSCA   = 3'd1,
      ACESO   = 3'd2,
      APAGADO = 3'd3,
      FIM     = 3'd4
   } estado_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic [DBG_W-1:0] codigo_estado(input estado_t e);
      return {1'b0, e};
   endfunction

endpackage

// File: rtl/exibe_sequencia_if.sv
// exibe_sequencia_if: control/ROM/LED signals of the sequence-presentation
// unit; master is the controller + ROM side, slave is the unit itself.
interface exibe_sequencia_if;
   import exibe_sequencia_pkg::*;

   logic              iniciar;
   logic [ADDR_W-1:0] limite;
   logic [DATA_W-1:0] dado;
   logic [ADDR_W-1:0] endereco;
   logic [DATA_W-1:0] leds;
   logic              ocupado;
   logic              pronto;
   logic [DBG_W-1:0]  db_estado;

   modport master (
      output iniciar,
      output limite,
      output dado,
      input  endereco,
      input  leds,
      input  ocupado,
      input  pronto,
      input  db_estado
   );

   modport slave (
      input  iniciar,
      input  limite,
      input  dado,
      output endereco,
      output leds,
      output ocupado,
      output pronto,
      output db_estado
   );

endinterface

// File: rtl/exibe_sequencia_contador_m.sv
// contador_m: generic modulo-M up-counter with synchronous clear and enable;
// fim flags the terminal count M-1.
module contador_m #(
   parameter int M = 1000,
   parameter int N = 10
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         zera,
   input  logic         conta,
   output logic [N-1:0] q,
   output logic         fim
);

   localparam logic [N-1:0] ULTIMO = N'(M - 1);

   logic [N-1:0] q_q;
   logic [N-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (zera) begin
         q_d = '0;
      end else if (conta) begin
         q_d = (q_q == ULTIMO) ? '0 : q_q + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q   = q_q;
   assign fim = (q_q == ULTIMO);

endmodule

// File: rtl/exibe_sequencia.sv
// exibe_sequencia: shows sequence memory entries 0..limite on the LEDs,
// each for T_ACESO cycles followed by a T_APAGADO-cycle blank gap.
module exibe_sequencia
   import exibe_sequencia_pkg::*;
#(
   parameter int T_ACESO   = 1000,
   parameter int T_APAGADO = 500,
   parameter int W_TIMER   = 10
) (
   input  logic             clock,
   input  logic             reset,
   exibe_sequencia_if.slave bus
);

   localparam int M = max_int(T_ACESO, T_APAGADO);

   localparam logic [W_TIMER-1:0] ULT_ACESO   = W_TIMER'(T_ACESO - 1);
   localparam logic [W_TIMER-1:0] ULT_APAGADO = W_TIMER'(T_APAGADO - 1);

   estado_t           estado_q;
   estado_t           estado_d;
   logic [ADDR_W-1:0] endereco_q;
   logic [ADDR_W-1:0] endereco_d;
   logic [ADDR_W-1:0] limite_q;
   logic [ADDR_W-1:0] limite_d;

   logic               zera;
   logic               conta;
   logic [W_TIMER-1:0] timer;
   logic               timer_fim;

   contador_m #(
      .M (M),
      .N (W_TIMER)
   ) u_timer (
      .clock (clock),
      .reset (reset),
      .zera  (zera),
      .conta (conta),
      .q     (timer),
      .fim   (timer_fim)
   );

   // The timer is held at zero except while it is timing a slot, so every
   // state change leaves it cleared for the next slot.
   always_comb begin
      estado_d   = estado_q;
      endereco_d = endereco_q;
      limite_d   = limite_q;
      zera       = 1'b1;
      conta      = 1'b0;

      case (estado_q)
         INICIAL: begin
            if (bus.iniciar) begin
               limite_d   = bus.limite;
               endereco_d = '0;
               estado_d   = BUSCA;
            end
         end

         BUSCA: begin
            estado_d = ACESO;
         end

         ACESO: begin
            if (timer == ULT_ACESO) begin
               estado_d = APAGADO;
            end else begin
               zera  = 1'b0;
               conta = 1'b1;
            end
         end

         APAGADO: begin
            if (timer == ULT_APAGADO) begin
               if (endereco_q == limite_q) begin
                  estado_d = FIM;
               end else begin
                  endereco_d = endereco_q + 1'b1;
                  estado_d   = BUSCA;
               end
            end else begin
               zera  = 1'b0;
               conta = 1'b1;
            end
         end

         FIM: begin
            estado_d = INICIAL;
         end

         default: begin
            estado_d = INICIAL;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_q   <= INICIAL;
         endereco_q <= '0;
         limite_q   <= '0;
      end else begin
         estado_q   <= estado_d;
         endereco_q <= endereco_d;
         limite_q   <= limite_d;
      end
   end

   // Outputs decode only registered state and the registered ROM word.
   assign bus.endereco  = endereco_q;
   assign bus.leds      = (estado_q == ACESO) ? bus.dado : '0;
   assign bus.ocupado   = (estado_q != INICIAL);
   assign bus.pronto    = (estado_q == FIM);
   assign bus.db_estado = codigo_estado(estado_q);

   a_timer_fim: assert property (
      @(posedge clock) disable iff (reset)
      timer_fim |-> (timer == W_TIMER'(M - 1))
   );

endmodule

// File: tb/tb_exibe_sequencia.sv
// tb_exibe_sequencia: randomized scoreboard bench; a per-run reference
// model predicts every cycle of LED, status and address activity.
module tb_exibe_sequencia;

   localparam int TA  = 4;
   localparam int TP  = 2;
   localparam int SLOT = 1 + TA + TP;

   typedef struct {
      int         cyc;
      logic [3:0] leds;
      logic       pronto;
      logic [3:0] ender;
      logic [3:0] est;
   } exp_t;

   logic clk;
   logic rst;
   logic [3:0] rom [16];

   exibe_sequencia_if bus ();

   exibe_sequencia #(
      .T_ACESO   (TA),
      .T_APAGADO (TP),
      .W_TIMER   (10)
   ) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) bus.dado <= rom[bus.endereco];

   exp_t       q[$];
   int         cyc        = 0;
   int         busy_until = -1000;
   logic [3:0] idle_end   = 4'd0;
   int         checks     = 0;
   int         errors     = 0;
   int         pronto_cnt = 0;
   int         pronto_cyc = -1;

   task automatic chk(input string nm, input logic [13:0] got,
                      input logic [13:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (leds,oc,pr,end,est)",
                  nm, got, exp);
      end
   endtask

   task automatic chk_int(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   task automatic push(input int c, input logic [3:0] l, input logic p,
                       input logic [3:0] a, input logic [3:0] e);
      exp_t r;
      r.cyc = c; r.leds = l; r.pronto = p; r.ender = a; r.est = e;
      q.push_back(r);
   endtask

   // One run: per entry a fetch cycle, TA lit cycles, TP dark cycles,
   // then a single done cycle holding the last address.
   task automatic push_run(input int e, input logic [3:0] lim);
      int c;
      int last;
      c = e + 1;
      last = int'(lim);
      for (int i = 0; i <= last; i++) begin
         push(c, 4'd0, 1'b0, 4'(i), 4'd1); c++;
         for (int k = 0; k < TA; k++) begin
            push(c, rom[i], 1'b0, 4'(i), 4'd2); c++;
         end
         for (int k = 0; k < TP; k++) begin
            push(c, 4'd0, 1'b0, 4'(i), 4'd3); c++;
         end
      end
      push(c, 4'd0, 1'b1, lim, 4'd4);
      busy_until = c;
      idle_end = lim;
   endtask

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (!rst && bus.iniciar === 1'b1 && cyc > busy_until)
         push_run(cyc, bus.limite);
   end

   always @(negedge clk) begin
      exp_t r;
      logic [13:0] got;
      got = {bus.leds, bus.ocupado, bus.pronto, bus.endereco, bus.db_estado};
      if (bus.pronto === 1'b1) begin
         pronto_cnt++;
         pronto_cyc = cyc + 1;
      end
      if (q.size() > 0 && q[0].cyc == cyc + 1) begin
         r = q.pop_front();
         chk("run", got, {r.leds, 1'b1, r.pronto, r.ender, r.est});
      end else begin
         chk("idle", got, {4'd0, 1'b0, 1'b0, idle_end, 4'd0});
      end
   end

   task automatic start(input logic [3:0] lim, output int s);
      @(negedge clk);
      bus.limite = lim;
      bus.iniciar = 1'b1;
      s = cyc + 1;
      @(negedge clk);
      bus.iniciar = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((q.size() != 0 || bus.ocupado !== 1'b0) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) begin
         errors++;
         $display("FAIL wait_idle: timeout got busy expected idle");
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic rom_padrao();
      logic [3:0] pad [4];
      pad[0] = 4'b0001; pad[1] = 4'b0010;
      pad[2] = 4'b0100; pad[3] = 4'b1000;
      for (int i = 0; i < 16; i++) rom[i] = pad[i % 4];
   endtask

   initial begin
      int s;
      int s0;
      int p0;
      logic [3:0] lim;

      rst = 1'b1;
      bus.iniciar = 1'b0;
      bus.limite = 4'd0;
      rom_padrao();
      repeat (3) @(negedge clk);
      chk("reset_state",
          {bus.leds, bus.ocupado, bus.pronto, bus.endereco, bus.db_estado},
          14'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Plain run, three entries.
      p0 = pronto_cnt;
      start(4'd2, s);
      wait_idle();
      chk_int("l2_pronto_cycle", pronto_cyc - s, 3 * SLOT + 1);
      chk_int("l2_pronto_count", pronto_cnt - p0, 1);

      // Asynchronous reset in the middle of the first lit slot.
      p0 = pronto_cnt;
      start(4'd3, s);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      q.delete();
      busy_until = -1000;
      idle_end = 4'd0;
      #1;
      chk("reset_mid_aceso",
          {bus.leds, bus.ocupado, bus.pronto, bus.endereco, bus.db_estado},
          14'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      chk_int("reset_no_pronto", pronto_cnt - p0, 0);

      // Single entry.
      p0 = pronto_cnt;
      start(4'd0, s);
      wait_idle();
      chk_int("l0_pronto_cycle", pronto_cyc - s, SLOT + 1);
      chk_int("l0_pronto_count", pronto_cnt - p0, 1);

      // Full memory with a dark entry.
      rom[7] = 4'b0000;
      p0 = pronto_cnt;
      start(4'd15, s);
      wait_idle();
      chk_int("l15_pronto_cycle", pronto_cyc - s, 16 * SLOT + 1);
      chk_int("l15_pronto_count", pronto_cnt - p0, 1);
      chk_int("l15_endereco", int'(bus.endereco), 15);
      rom_padrao();

      // Restart request with a new limit while busy is ignored.
      p0 = pronto_cnt;
      start(4'd1, s);
      repeat (4) @(negedge clk);
      bus.limite = 4'd9;
      bus.iniciar = 1'b1;
      @(negedge clk);
      bus.iniciar = 1'b0;
      wait_idle();
      chk_int("repulse_pronto_cycle", pronto_cyc - s, 2 * SLOT + 1);
      chk_int("repulse_pronto_count", pronto_cnt - p0, 1);

      // Start held high: back-to-back runs one idle cycle apart.
      p0 = pronto_cnt;
      @(negedge clk);
      bus.limite = 4'd0;
      bus.iniciar = 1'b1;
      s0 = cyc + 1;
      repeat (18) @(negedge clk);
      bus.iniciar = 1'b0;
      wait_idle();
      chk_int("held_pronto_count", pronto_cnt - p0, 2);
      chk_int("held_pronto_cycle", pronto_cyc - s0, 2 * (SLOT + 1) + 1);

      // Random contents, limits and stray start pulses.
      for (int it = 0; it < 8; it++) begin
         for (int i = 0; i < 16; i++) rom[i] = 4'($urandom_range(0, 15));
         lim = 4'($urandom_range(0, 15));
         p0 = pronto_cnt;
         start(lim, s);
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 10)) @(negedge clk);
            bus.limite = 4'($urandom_range(0, 15));
            bus.iniciar = 1'b1;
            @(negedge clk);
            bus.iniciar = 1'b0;
         end
         wait_idle();
         chk_int("rand_pronto_cycle", pronto_cyc - s,
                 (int'(lim) + 1) * SLOT + 1);
         chk_int("rand_pronto_count", pronto_cnt - p0, 1);
      end

      chk_int("queue_drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
